// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through byte FIFO.
// The line is sampled mid-bit through a 2-flop synchronizer. Bytes arrive LSB first.
// An optional parity bit and the stop bit are checked before a byte is buffered.
// Bad frames and FIFO overflows are reported as registered 1-cycle pulses.
// FIFO handshake: rd_en pops the head byte on a clock edge only while empty is low;
// rd_data is the head byte whenever empty is low and reads 0 otherwise.
module uart_rx_fifo #(
  parameter int SYS_CLK_FREQ   = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int PARITY_MODE    = 0,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overrun,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CPB   = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int PTR_W = FIFO_ADDR_BITS + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bad_q, par_bad_d;
  logic             sync1_q, sync2_q;
  logic             rx_s;
  logic             push, fe_d, pe_d;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             pop, push_ok, ov_d;
  logic             overrun_q, parity_err_q, frame_err_q;

  assign rx_s = sync2_q;

  // Bring the asynchronous line into the clock domain; idle level is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Frame sequencing: half a bit to centre on the start bit, then one full bit per sample.
  // Leaving STOP at its mid-point leaves half a bit of slack before the next start edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push      = 1'b0;
    fe_d      = 1'b0;
    pe_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_d     = 3'd0;
            par_bad_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (PARITY_MODE == 1) ? ~(^{shift_q, rx_s}) : (^{shift_q, rx_s});
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end else if (par_bad_q) begin
            pe_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO survives only then.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FIFO_ADDR_BITS] != rd_ptr_q[FIFO_ADDR_BITS]) &&
                   (wr_ptr_q[FIFO_ADDR_BITS-1:0] == rd_ptr_q[FIFO_ADDR_BITS-1:0]);
  assign pop     = rd_en && !empty;
  assign push_ok = push && (!full || pop);
  assign ov_d    = push && full && !pop;
  assign rd_data = empty ? 8'h00 : mem[rd_ptr_q[FIFO_ADDR_BITS-1:0]];

  // Byte storage; only the pointers need a reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[FIFO_ADDR_BITS-1:0]] <= shift_q;
  end

  // FIFO pointers and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      overrun_q    <= ov_d;
      parity_err_q <= pe_d;
      frame_err_q  <= fe_d;
    end
  end

  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (no parity/depth 8, even/depth 4, odd/depth 8).
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rx_v, rd_en_v;
  logic [2:0]  empty_v, full_v, ov_v, pe_v, fe_v;
  logic [23:0] rd_data_v;

  always #5 clk = ~clk;

  uart_rx_fifo #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY_MODE(0), .FIFO_ADDR_BITS(3)) dut0 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .rd_en(rd_en_v[0]), .rd_data(rd_data_v[7:0]),
    .empty(empty_v[0]), .full(full_v[0]), .overrun(ov_v[0]), .parity_err(pe_v[0]), .frame_err(fe_v[0]));
  uart_rx_fifo #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY_MODE(2), .FIFO_ADDR_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .rd_en(rd_en_v[1]), .rd_data(rd_data_v[15:8]),
    .empty(empty_v[1]), .full(full_v[1]), .overrun(ov_v[1]), .parity_err(pe_v[1]), .frame_err(fe_v[1]));
  uart_rx_fifo #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY_MODE(1), .FIFO_ADDR_BITS(3)) dut2 (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .rd_en(rd_en_v[2]), .rd_data(rd_data_v[23:16]),
    .empty(empty_v[2]), .full(full_v[2]), .overrun(ov_v[2]), .parity_err(pe_v[2]), .frame_err(fe_v[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int obs_fe[3] = '{0, 0, 0};
  int obs_pe[3] = '{0, 0, 0};
  int obs_ov[3] = '{0, 0, 0};
  int s_fe, s_pe, s_ov;
  int m_fe, m_pe, m_ov;
  int lat;
  logic [7:0] exp_q[$];

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       par_good;
    logic       stop;
    int         exp_fe;
    int         exp_pe;
    int         exp_store;
  } vec_t;
  vec_t vecs[10];

  // Pulse monitor: a pulse stretched over several cycles is counted several times.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fe_v[i]) obs_fe[i] = obs_fe[i] + 1;
      if (pe_v[i]) obs_pe[i] = obs_pe[i] + 1;
      if (ov_v[i]) obs_ov[i] = obs_ov[i] + 1;
    end
  end

  function automatic int mode_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  function automatic int depth_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  // Odd: data plus parity holds an odd number of ones; even: an even number.
  function automatic logic par_bit(input int i, input logic [7:0] d, input logic good);
    logic p;
    p = (mode_of(i) == 1) ? ~(^d) : (^d);
    return good ? p : ~p;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic snap(input int i);
    s_fe = obs_fe[i];
    s_pe = obs_pe[i];
    s_ov = obs_ov[i];
  endtask

  task automatic check_pulses(input int i, input string name, input int efe, input int epe, input int eov);
    check({name, " frame_err pulses"},  obs_fe[i] - s_fe, efe);
    check({name, " parity_err pulses"}, obs_pe[i] - s_pe, epe);
    check({name, " overrun pulses"},    obs_ov[i] - s_ov, eov);
  endtask

  task automatic idle(input int i, input int n);
    rx_v[i] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int i, input logic v);
    rx_v[i] = v;
    repeat (CPB) @(negedge clk);
  endtask

  // A bad stop bit is followed by a held-low line, then idle so the break ends.
  task automatic send_frame(input int i, input logic [7:0] d, input logic par_good, input logic stop);
    drive_bit(i, 1'b0);
    for (int b = 0; b < 8; b++) drive_bit(i, d[b]);
    if (mode_of(i) != 0) drive_bit(i, par_bit(i, d, par_good));
    drive_bit(i, stop);
    if (!stop) begin
      rx_v[i] = 1'b0;
      repeat (24) @(negedge clk);
      idle(i, 2 * CPB);
    end
  endtask

  task automatic pop_check(input int i, input logic [7:0] expv, input string name);
    check({name, " not empty"}, int'(empty_v[i]), 0);
    check({name, " rd_data"}, int'(rd_data_v[i*8 +: 8]), int'(expv));
    rd_en_v[i] = 1'b1;
    @(negedge clk);
    rd_en_v[i] = 1'b0;
  endtask

  // Reference outcome of one frame, in decision order: stop, parity, room in the FIFO.
  task automatic model_frame(input int i, input logic [7:0] d, input logic par_good, input logic stop);
    if (!stop) m_fe++;
    else if (mode_of(i) != 0 && !par_good) m_pe++;
    else if (exp_q.size() == depth_of(i)) m_ov++;
    else exp_q.push_back(d);
  endtask

  task automatic drain(input int i);
    while (exp_q.size() > 0) pop_check(i, exp_q.pop_front(), "rand pop");
    check("rand drained empty", int'(empty_v[i]), 1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    rx_v    = 3'b111;
    rd_en_v = 3'b000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset empty", int'(empty_v[i]), 1);
      check("reset full", int'(full_v[i]), 0);
      check("reset rd_data", int'(rd_data_v[i*8 +: 8]), 0);
      check("reset pulses", int'({ov_v[i], pe_v[i], fe_v[i]}), 0);
    end
    rst = 1'b0;
    idle(0, 5);

    // Single byte, latency from start edge to data visible.
    snap(0);
    lat = 0;
    fork
      send_frame(0, 8'hA5, 1'b1, 1'b1);
      begin
        while (empty_v[0] && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check_range("t1 latency", lat, 148, 162);
    pop_check(0, 8'hA5, "t1");
    check("t1 empty after pop", int'(empty_v[0]), 1);
    rd_en_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    rd_en_v[0] = 1'b0;
    check("t1 pop on empty keeps empty", int'(empty_v[0]), 1);
    check("t1 pop on empty not full", int'(full_v[0]), 0);
    check_pulses(0, "t1", 0, 0, 0);

    // Back-to-back frames with a single stop bit.
    snap(0);
    send_frame(0, 8'h00, 1'b1, 1'b1);
    send_frame(0, 8'hFF, 1'b1, 1'b1);
    send_frame(0, 8'h3C, 1'b1, 1'b1);
    idle(0, 4);
    pop_check(0, 8'h00, "t2 b0");
    pop_check(0, 8'hFF, "t2 b1");
    pop_check(0, 8'h3C, "t2 b2");
    check("t2 empty", int'(empty_v[0]), 1);
    check_pulses(0, "t2", 0, 0, 0);

    // Short low glitch is rejected.
    snap(0);
    rx_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    idle(0, 100);
    check("t3 empty after glitch", int'(empty_v[0]), 1);
    check_pulses(0, "t3", 0, 0, 0);
    send_frame(0, 8'h6E, 1'b1, 1'b1);
    idle(0, 2);
    pop_check(0, 8'h6E, "t3 after glitch");

    // Framing error followed by a long low line, then recovery.
    snap(0);
    send_frame(0, 8'h55, 1'b1, 1'b0);
    check_pulses(0, "t4", 1, 0, 0);
    check("t4 empty", int'(empty_v[0]), 1);
    send_frame(0, 8'h12, 1'b1, 1'b1);
    idle(0, 2);
    pop_check(0, 8'h12, "t4 recovery");

    // Table of frames across the three parity modes.
    vecs[0] = '{0, 8'h3A, 1'b1, 1'b1, 0, 0, 1};
    vecs[1] = '{0, 8'h81, 1'b1, 1'b0, 1, 0, 0};
    vecs[2] = '{1, 8'h07, 1'b0, 1'b1, 0, 1, 0};
    vecs[3] = '{1, 8'h07, 1'b1, 1'b1, 0, 0, 1};
    vecs[4] = '{1, 8'hF0, 1'b1, 1'b0, 1, 0, 0};
    vecs[5] = '{1, 8'hF1, 1'b0, 1'b0, 1, 0, 0};
    vecs[6] = '{2, 8'h07, 1'b1, 1'b1, 0, 0, 1};
    vecs[7] = '{2, 8'h07, 1'b0, 1'b1, 0, 1, 0};
    vecs[8] = '{2, 8'hFF, 1'b0, 1'b0, 1, 0, 0};
    vecs[9] = '{2, 8'h00, 1'b1, 1'b1, 0, 0, 1};
    for (int v = 0; v < 10; v++) begin
      snap(vecs[v].dut);
      send_frame(vecs[v].dut, vecs[v].data, vecs[v].par_good, vecs[v].stop);
      idle(vecs[v].dut, 4);
      check_pulses(vecs[v].dut, $sformatf("vec%0d", v), vecs[v].exp_fe, vecs[v].exp_pe, 0);
      if (vecs[v].exp_store != 0) pop_check(vecs[v].dut, vecs[v].data, $sformatf("vec%0d", v));
      check($sformatf("vec%0d empty", v), int'(empty_v[vecs[v].dut]), 1);
    end

    // Fill the depth-4 FIFO and overflow it.
    snap(1);
    for (int b = 1; b <= 5; b++) begin
      send_frame(1, 8'(b), 1'b1, 1'b1);
      idle(1, 2);
      check($sformatf("t6 full after %0d", b), int'(full_v[1]), (b >= 4) ? 1 : 0);
    end
    check_pulses(1, "t6", 0, 0, 1);
    for (int b = 1; b <= 4; b++) pop_check(1, 8'(b), "t6 pop");
    check("t6 empty", int'(empty_v[1]), 1);

    // Reset in the middle of a data bit with bytes queued.
    send_frame(0, 8'h11, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b1, 1'b1);
    snap(0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rx_v[0] = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t7 empty during reset", int'(empty_v[0]), 1);
    check("t7 rd_data during reset", int'(rd_data_v[7:0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(0, 20);
    send_frame(0, 8'h9C, 1'b1, 1'b1);
    idle(0, 2);
    pop_check(0, 8'h9C, "t7 after reset");
    check("t7 empty", int'(empty_v[0]), 1);
    check_pulses(0, "t7", 0, 0, 0);

    // Random frames against the reference model.
    for (int i = 0; i < 3; i++) begin
      exp_q.delete();
      m_fe = 0;
      m_pe = 0;
      m_ov = 0;
      snap(i);
      for (int f = 0; f < 20; f++) begin
        logic [7:0] d;
        logic       pg, st;
        d  = 8'($urandom);
        st = ($urandom_range(0, 7) != 0);
        pg = ($urandom_range(0, 3) != 0);
        send_frame(i, d, pg, st);
        model_frame(i, d, pg, st);
        idle(i, $urandom_range(2, 20));
        check_pulses(i, "rand", m_fe, m_pe, m_ov);
        check("rand empty", int'(empty_v[i]), (exp_q.size() == 0) ? 1 : 0);
        check("rand full", int'(full_v[i]), (exp_q.size() == depth_of(i)) ? 1 : 0);
        if ($urandom_range(0, 4) == 0) drain(i);
      end
      drain(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
